// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 4-bit ALU with a single transaction
// in flight. Arbitration is round-robin (FAIR=1) or fixed priority with
// requester 0 highest (FAIR=0). An accepted operation executes for one
// cycle, then its result is held on rsp_result with the granted
// requester's rspN_valid until that requester takes it.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid / reqN_ready      operation handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_sel     operands and opcode (00 add, 01 and, 10 or, 11 xor)
//   rspN_valid / rspN_ready      result handshake per requester
//   rsp_result                   shared result bus
//   busy                         high whenever the FSM is not idle
//   txn_count                    completed responses, wraps at 256

// 4-bit combinational ALU; add wraps modulo 16.
module alu4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    always_comb begin
        y = '0;
        case (sel)
            2'b00:   y = a + b;
            2'b01:   y = a & b;
            2'b10:   y = a | b;
            default: y = a ^ b;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_sel,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [3:0] rsp_result,
    output logic       busy,
    output logic [7:0] txn_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic [3:0] a_q, b_q;
    logic [1:0] sel_q;
    logic       gnt_q;     // requester owning the in-flight transaction
    logic       last_gnt;  // requester of the most recently completed transaction
    logic [3:0] alu_y;
    logic       gnt_any;
    logic       gnt_id;

    alu4 u_alu (
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q),
        .y   (alu_y)
    );

    // Tie-break: round-robin favours whoever was not served last.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            gnt_id = (FAIR != 0) ? ~last_gnt : 1'b0;
        else
            gnt_id = req1_valid;
    end

    assign req0_ready = (state == IDLE) && !rst && gnt_any && !gnt_id;
    assign req1_ready = (state == IDLE) && !rst && gnt_any &&  gnt_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            gnt_q      <= 1'b0;
            last_gnt   <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            busy       <= 1'b0;
            txn_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        a_q   <= gnt_id ? req1_a   : req0_a;
                        b_q   <= gnt_id ? req1_b   : req0_b;
                        sel_q <= gnt_id ? req1_sel : req0_sel;
                        gnt_q <= gnt_id;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_y;
                    rsp0_valid <= ~gnt_q;
                    rsp1_valid <= gnt_q;
                    state      <= RESP;
                end
                RESP: begin
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        txn_count  <= txn_count + 8'd1;
                        last_gnt   <= gnt_q;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 highest.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output 1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-007 req0_sel  input  2  requester 0 opcode: 00 add, 01 AND, 10 OR, 11 XOR.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same directions and widths as REQ-004..007, for requester 1.
REQ-009 rsp0_valid  output 1  result for requester 0 available.
REQ-010 rsp0_ready  input  1  requester 0 consumes the result.
REQ-011 rsp1_valid, rsp1_ready  same as REQ-009..010, for requester 1.
REQ-012 rsp_result  output 4  shared result bus, meaningful only while rsp0_valid or rsp1_valid is high.
REQ-013 busy  output 1  high in every state except IDLE.
REQ-014 txn_count  output 8  count of completed responses.

Function
REQ-015 The block SHALL contain exactly one instance of the 4-bit combinational ALU, shared by both requesters, with one transaction in flight at a time.
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 In IDLE with at least one reqN_valid high, the arbiter SHALL assert reqN_ready combinationally for exactly one requester, latch its a/b/sel and grant ID, and move to EXEC on that edge.
REQ-018 reqN_ready SHALL be low in EXEC and RESP, low during reset, and never high for both requesters in the same cycle.
REQ-019 With FAIR=1, a tie SHALL be granted to the requester not granted last; the last-grant register resets to 1, so requester 0 wins the first tie.
REQ-020 With FAIR=0, requester 0 SHALL always win a tie.
REQ-021 In EXEC, the ALU output computed from the latched operands SHALL be registered into rsp_result, with a move to RESP after exactly one cycle.
REQ-022 Add results SHALL wrap modulo 16 with no carry out; AND/OR/XOR results SHALL be bitwise over 4 bits.
REQ-023 Latency: an accept at edge N SHALL produce rspN_valid high from edge N+2.
REQ-024 In RESP, only the granted requester's rspN_valid SHALL be high, and rsp_result SHALL be held stable until rspN_ready is sampled high.
REQ-025 On an edge with rspN_valid and rspN_ready both high, the block SHALL return to IDLE, increment txn_count (255 wraps to 0) and update the last-grant register.
REQ-026 A new request SHALL NOT be accepted in the same cycle a response completes; earliest re-accept is the cycle after the return to IDLE.
REQ-027 Operand changes on req inputs after acceptance SHALL have no effect on the in-flight result.

Reset
REQ-028 When rst is asserted, the block SHALL immediately force state to IDLE, clear all outputs and latched operands to 0, clear txn_count to 0 and set last-grant to 1, independent of clk.
REQ-029 A transaction interrupted by reset SHALL be discarded, with no response issued after rst deasserts.

Verification
REQ-030 Single request: req0 a=0011 b=0101 sel=00, accepted at edge N -> rsp0_valid at N+2, rsp_result=1000, txn_count=1.
REQ-031 Add wrap: req1 a=1001 b=1001 sel=00 -> rsp1_valid, rsp_result=0010, rsp0_valid stays 0.
REQ-032 Tie after reset with FAIR=1: req0 AND 1100/1010 and req1 OR 1100/1010 -> req0 served first (1000), then req1 (1110); with both held valid, grants alternate 0,1,0,1.
REQ-033 Backpressure: rsp0_ready held low for 5 cycles in RESP -> rsp0_valid and rsp_result=0110 (XOR 1100/1010) stable, req1_ready stays 0, busy=1.
REQ-034 Reset during EXEC -> all outputs 0 immediately, txn_count=0, no rsp valid after release, next request served normally.
REQ-035 FAIR=0 with both requesters continuously valid -> only requester 0 granted across 4 transactions, txn_count=4.
